// File: rtl/sdk_uart_pkg.sv
// ---------------------------------------------------------------------------
// sdk_uart_pkg
// Shared definitions for the SDK byte-stream UART transmitter.
//   - FSM state encodings (IDLE=0, START=1, DATA=2, STOP=3, PARITY=4)
//   - uart_state_e : FSM state type; PARITY exists only with SDK_UART_PARITY_EN
//   - UART_IDLE_LVL: level of the serial line when nothing is sent
//   - DATA_BITS    : payload bits per frame
//   - even_parity(): even-parity bit of one payload byte
// Configuration macro: SDK_UART_PARITY_EN
// ---------------------------------------------------------------------------
package sdk_uart_pkg;

    localparam logic [2:0] ST_IDLE_ENC   = 3'd0;
    localparam logic [2:0] ST_START_ENC  = 3'd1;
    localparam logic [2:0] ST_DATA_ENC   = 3'd2;
    localparam logic [2:0] ST_STOP_ENC   = 3'd3;
    localparam logic [2:0] ST_PARITY_ENC = 3'd4;

    localparam logic UART_IDLE_LVL = 1'b1;
    localparam int   DATA_BITS     = 8;

    typedef enum logic [2:0] {
        S_IDLE   = ST_IDLE_ENC,
        S_START  = ST_START_ENC,
        S_DATA   = ST_DATA_ENC,
        S_STOP   = ST_STOP_ENC
`ifdef SDK_UART_PARITY_EN
        ,
        S_PARITY = ST_PARITY_ENC
`endif
    } uart_state_e;

    // Even parity: the bit that makes the total number of ones even.
    function automatic logic even_parity(input logic [DATA_BITS-1:0] b);
        return ^b;
    endfunction

endpackage

// File: rtl/sdk_byte_fifo.sv
// ---------------------------------------------------------------------------
// sdk_byte_fifo
// Small synchronous byte FIFO with a sticky overflow flag.
// Ports:
//   clk        in   clock, posedge
//   rst_n      in   asynchronous active-low reset (clears pointers, count, flag)
//   i_wr_en    in   write request; ignored (and flagged) when full
//   i_wr_dat   in   byte to store
//   i_rd_en    in   pop request; ignored when empty
//   i_clr_ovf  in   clear overflow flag (a simultaneous overflow wins)
//   o_rd_dat   out  head of the FIFO (valid while !o_empty)
//   o_full     out  count == FIFO_DEPTH
//   o_empty    out  count == 0
//   o_ovf      out  sticky: a write was dropped because the FIFO was full
// ---------------------------------------------------------------------------
module sdk_byte_fifo
    import sdk_uart_pkg::*;
#(
    parameter int FIFO_DEPTH = 8,
    parameter int FIFO_AW    = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_wr_en,
    input  logic [DATA_BITS-1:0] i_wr_dat,
    input  logic                 i_rd_en,
    input  logic                 i_clr_ovf,
    output logic [DATA_BITS-1:0] o_rd_dat,
    output logic                 o_full,
    output logic                 o_empty,
    output logic                 o_ovf
);

    localparam int CNT_W = FIFO_AW + 1;
    localparam logic [CNT_W-1:0]   CNT_FULL = CNT_W'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0]   CNT_ONE  = CNT_W'(1);
    localparam logic [FIFO_AW-1:0] PTR_ONE  = FIFO_AW'(1);

    logic [DATA_BITS-1:0] r_mem [FIFO_DEPTH];
    logic [FIFO_AW-1:0]   r_wr_ptr;
    logic [FIFO_AW-1:0]   r_rd_ptr;
    logic [CNT_W-1:0]     r_count;
    logic                 r_ovf;
    logic                 w_wr;
    logic                 w_rd;

    // Flags come straight from the registered count, so a write in the
    // same cycle as the last free slot is judged on the start-of-cycle count.
    assign o_full   = (r_count == CNT_FULL);
    assign o_empty  = (r_count == '0);
    assign w_wr     = i_wr_en & ~o_full;
    assign w_rd     = i_rd_en & ~o_empty;
    assign o_rd_dat = r_mem[r_rd_ptr];
    assign o_ovf    = r_ovf;

    // Storage carries no reset; stale entries are unreachable once the
    // pointers and count are cleared.
    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= i_wr_dat;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_ovf    <= 1'b0;
        end else begin
            // Pointers wrap naturally because FIFO_DEPTH == 2**FIFO_AW.
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            if (w_rd) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
            case ({w_wr, w_rd})
                2'b10:   r_count <= r_count + CNT_ONE;
                2'b01:   r_count <= r_count - CNT_ONE;
                default: r_count <= r_count;
            endcase
            if (i_wr_en && o_full) begin
                r_ovf <= 1'b1;
            end else if (i_clr_ovf) begin
                r_ovf <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/sdk_dat_uart_tx.sv
// ---------------------------------------------------------------------------
// sdk_dat_uart_tx
// Buffers the SPI slave's SDK byte stream and sends each byte as a UART
// frame (8N1; 8E1 with SDK_UART_PARITY_EN defined) on a single pin.
// Configuration macro: SDK_UART_PARITY_EN (adds an even-parity bit)
// Ports:
//   sys_clk     in   clock, posedge
//   rst_n       in   asynchronous active-low reset
//   in_dval     in   one-cycle strobe: in_dat valid
//   in_dat      in   byte from spi_slave_ctrl
//   clr_ovf     in   clear ovf_flag
//   uart_txd    out  serial line, idles high, registered
//   tx_busy     out  high while a frame is on the line
//   fifo_full   out  FIFO holds FIFO_DEPTH bytes
//   fifo_empty  out  FIFO holds no byte
//   ovf_flag    out  sticky: a byte was dropped on a full FIFO
// ---------------------------------------------------------------------------
module sdk_dat_uart_tx
    import sdk_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter int FIFO_DEPTH   = 8,
    parameter int FIFO_AW      = 3
) (
    input  logic                 sys_clk,
    input  logic                 rst_n,
    input  logic                 in_dval,
    input  logic [DATA_BITS-1:0] in_dat,
    input  logic                 clr_ovf,
    output logic                 uart_txd,
    output logic                 tx_busy,
    output logic                 fifo_full,
    output logic                 fifo_empty,
    output logic                 ovf_flag
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int BW = $clog2(DATA_BITS);
    localparam logic [CW-1:0] CYC_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CYC_ONE  = CW'(1);
    localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);
    localparam logic [BW-1:0] BIT_ONE  = BW'(1);

    uart_state_e          r_state;
    logic [CW-1:0]        r_cyc;
    logic [BW-1:0]        r_bit_cnt;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_txd;
    logic                 r_busy;
`ifdef SDK_UART_PARITY_EN
    logic                 r_par;
`endif

    logic [DATA_BITS-1:0] w_head;
    logic                 w_empty;
    logic                 w_bit_end;
    logic                 w_pop;

    sdk_byte_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .FIFO_AW    (FIFO_AW)
    ) u_fifo (
        .clk        (sys_clk),
        .rst_n      (rst_n),
        .i_wr_en    (in_dval),
        .i_wr_dat   (in_dat),
        .i_rd_en    (w_pop),
        .i_clr_ovf  (clr_ovf),
        .o_rd_dat   (w_head),
        .o_full     (fifo_full),
        .o_empty    (w_empty),
        .o_ovf      (ovf_flag)
    );

    assign fifo_empty = w_empty;
    assign w_bit_end  = (r_cyc == CYC_LAST);
    // Pop when idle, or at the very end of STOP so the next frame follows
    // without an idle gap.
    assign w_pop = ~w_empty &
                   ((r_state == S_IDLE) | ((r_state == S_STOP) & w_bit_end));

    assign uart_txd = r_txd;
    assign tx_busy  = r_busy;

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_cyc     <= '0;
            r_bit_cnt <= '0;
            r_shift   <= '0;
            r_txd     <= UART_IDLE_LVL;
            r_busy    <= 1'b0;
`ifdef SDK_UART_PARITY_EN
            r_par     <= 1'b0;
`endif
        end else begin
            // Line and busy are registered from the state held during this
            // cycle, so each trails the FSM by one clock but every bit still
            // lasts exactly CLKS_PER_BIT cycles.
            r_busy <= (r_state != S_IDLE);
            case (r_state)
                S_START:  r_txd <= 1'b0;
                S_DATA:   r_txd <= r_shift[0];
                S_STOP:   r_txd <= 1'b1;
`ifdef SDK_UART_PARITY_EN
                S_PARITY: r_txd <= r_par;
`endif
                default:  r_txd <= UART_IDLE_LVL;
            endcase

            case (r_state)
                S_IDLE: begin
                    r_cyc <= '0;
                    if (w_pop) begin
                        r_shift <= w_head;
`ifdef SDK_UART_PARITY_EN
                        r_par   <= even_parity(w_head);
`endif
                        r_state <= S_START;
                    end
                end
                S_START: begin
                    if (w_bit_end) begin
                        r_cyc     <= '0;
                        r_bit_cnt <= '0;
                        r_state   <= S_DATA;
                    end else begin
                        r_cyc <= r_cyc + CYC_ONE;
                    end
                end
                S_DATA: begin
                    if (w_bit_end) begin
                        r_cyc   <= '0;
                        r_shift <= {1'b0, r_shift[DATA_BITS-1:1]};
                        if (r_bit_cnt == BIT_LAST) begin
`ifdef SDK_UART_PARITY_EN
                            r_state <= S_PARITY;
`else
                            r_state <= S_STOP;
`endif
                        end else begin
                            r_bit_cnt <= r_bit_cnt + BIT_ONE;
                        end
                    end else begin
                        r_cyc <= r_cyc + CYC_ONE;
                    end
                end
`ifdef SDK_UART_PARITY_EN
                S_PARITY: begin
                    if (w_bit_end) begin
                        r_cyc   <= '0;
                        r_state <= S_STOP;
                    end else begin
                        r_cyc <= r_cyc + CYC_ONE;
                    end
                end
`endif
                S_STOP: begin
                    if (w_bit_end) begin
                        r_cyc <= '0;
                        if (w_pop) begin
                            r_shift <= w_head;
`ifdef SDK_UART_PARITY_EN
                            r_par   <= even_parity(w_head);
`endif
                            r_state <= S_START;
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end else begin
                        r_cyc <= r_cyc + CYC_ONE;
                    end
                end
                default: begin
                    r_cyc   <= '0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
